// File: rtl/wash_pkg.sv
// wash_pkg: shared definitions for the washing-machine run-phase countdown.
//   - state_t      : FSM state encoding (IDLE, WASH, RINSE, SPIN, DONE)
//   - PH_*         : phase codes presented on the display/status bus
//   - DEF_*        : default widths and limits used as parameter defaults
//   - phase_of()   : maps an FSM state onto its externally visible phase code
package wash_pkg;

  localparam int DEF_TIME_W     = 7;
  localparam int DEF_MAX_TIME   = 99;
  localparam int DEF_BUZZ_TICKS = 3;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_WASH  = 2'd1;
  localparam logic [1:0] PH_RINSE = 2'd2;
  localparam logic [1:0] PH_SPIN  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WASH  = 3'd1,
    S_RINSE = 3'd2,
    S_SPIN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // DONE shares the spin/done phase code so the display keeps showing
  // the last phase while the buzzer sounds.
  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      S_WASH:         phase_of = PH_WASH;
      S_RINSE:        phase_of = PH_RINSE;
      S_SPIN, S_DONE: phase_of = PH_SPIN;
      default:        phase_of = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wash_countdown_if.sv
// wash_countdown_if: key/timer inputs and status outputs of the countdown.
//   master (controller/panel side): drives clk_1hz, start, pause, settimer;
//                                   reads the status outputs.
//   slave  (wash_countdown)       : reads the inputs; drives running, paused,
//                                   phase, remaining, tens, ones, done, buzzer.
interface wash_countdown_if
  import wash_pkg::*;
#(
  parameter int TIME_W = DEF_TIME_W
);
  logic              clk_1hz;
  logic              start;
  logic              pause;
  logic [TIME_W-1:0] settimer;
  logic              running;
  logic              paused;
  logic [1:0]        phase;
  logic [TIME_W-1:0] remaining;
  logic [3:0]        tens;
  logic [3:0]        ones;
  logic              done;
  logic              buzzer;

  modport master (
    output clk_1hz, start, pause, settimer,
    input  running, paused, phase, remaining, tens, ones, done, buzzer
  );

  modport slave (
    input  clk_1hz, start, pause, settimer,
    output running, paused, phase, remaining, tens, ones, done, buzzer
  );
endinterface

// File: rtl/edge_sync.sv
// edge_sync: brings an asynchronous level into the clk domain through two
// flops and emits a registered one-cycle pulse on its rising edge.
//   clk, rst : system clock, asynchronous active-high reset
//   din      : asynchronous level input
//   pulse    : one-clk pulse, three clk edges after din rises
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);
  // sh[1:0] is the synchronizer, sh[2] remembers the previous synced level.
  // Registering the pulse keeps it glitch-free for the FSM.
  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh    <= '0;
      pulse <= 1'b0;
    end else begin
      sh    <= {sh[1:0], din};
      pulse <= sh[1] & ~sh[2];
    end
  end
endmodule

// File: rtl/wash_countdown.sv
// wash_countdown: run-phase countdown engine of the washing machine.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : wash_countdown_if.slave
//              in : clk_1hz (tick source), start, pause (key levels), settimer
//              out: running, paused, phase, remaining, tens/ones (BCD),
//                   done (one-cycle completion pulse), buzzer
// A start edge in IDLE latches the clamped set time; each unpaused tick
// counts it down, and the phase is chosen by comparing the count against
// half and quarter of the latched time.
module wash_countdown
  import wash_pkg::*;
#(
  parameter int TIME_W     = DEF_TIME_W,
  parameter int MAX_TIME   = DEF_MAX_TIME,
  parameter int BUZZ_TICKS = DEF_BUZZ_TICKS
) (
  input logic             clk,
  input logic             rst,
  wash_countdown_if.slave bus
);
  localparam int BUZZ_W = $clog2(BUZZ_TICKS + 1);

  logic tick, st_e, pz_e;

  edge_sync u_sync_tick  (.clk(clk), .rst(rst), .din(bus.clk_1hz), .pulse(tick));
  edge_sync u_sync_start (.clk(clk), .rst(rst), .din(bus.start),   .pulse(st_e));
  edge_sync u_sync_pause (.clk(clk), .rst(rst), .din(bus.pause),   .pulse(pz_e));

  state_t            state, state_nx;
  logic [TIME_W-1:0] remaining, remaining_nx;
  logic [TIME_W-1:0] half, half_nx;
  logic [TIME_W-1:0] quarter, quarter_nx;
  logic              paused, paused_nx;
  logic [BUZZ_W-1:0] buzz_cnt, buzz_cnt_nx;
  logic              done, done_nx;

  logic [TIME_W-1:0] t_set;
  logic [TIME_W-1:0] rem_dec;
  logic [BUZZ_W-1:0] buzz_dec;
  logic              tick_applied;

  // Clamp keeps the display at two digits; the decrements saturate at 0.
  assign t_set    = (bus.settimer > TIME_W'(MAX_TIME)) ? TIME_W'(MAX_TIME) : bus.settimer;
  assign rem_dec  = (remaining != '0) ? remaining - TIME_W'(1) : '0;
  assign buzz_dec = (buzz_cnt != '0) ? buzz_cnt - BUZZ_W'(1) : '0;

  // A pause edge in the same cycle as a tick swallows that tick.
  assign tick_applied = tick & ~paused & ~pz_e;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      half      <= '0;
      quarter   <= '0;
      paused    <= 1'b0;
      buzz_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      half      <= half_nx;
      quarter   <= quarter_nx;
      paused    <= paused_nx;
      buzz_cnt  <= buzz_cnt_nx;
      done      <= done_nx;
    end
  end

  // Next-state logic: phase is picked from the post-decrement count, so
  // short runs may jump straight past WASH or RINSE.
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    half_nx      = half;
    quarter_nx   = quarter;
    paused_nx    = paused;
    buzz_cnt_nx  = buzz_cnt;
    done_nx      = 1'b0;

    case (state)
      S_IDLE: begin
        if (st_e && (t_set != '0)) begin
          remaining_nx = t_set;
          half_nx      = t_set >> 1;
          quarter_nx   = t_set >> 2;
          paused_nx    = 1'b0;
          state_nx     = S_WASH;
        end
      end

      S_WASH, S_RINSE, S_SPIN: begin
        if (pz_e) begin
          paused_nx = ~paused;
        end
        if (tick_applied) begin
          remaining_nx = rem_dec;
          if (rem_dec == '0) begin
            state_nx    = S_DONE;
            done_nx     = 1'b1;
            buzz_cnt_nx = BUZZ_W'(BUZZ_TICKS);
          end else if (rem_dec > half) begin
            state_nx = S_WASH;
          end else if (rem_dec > quarter) begin
            state_nx = S_RINSE;
          end else begin
            state_nx = S_SPIN;
          end
        end
      end

      S_DONE: begin
        if (tick) begin
          buzz_cnt_nx = buzz_dec;
          if (buzz_dec == '0) begin
            state_nx = S_IDLE;
          end
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.running   = (state == S_WASH) || (state == S_RINSE) || (state == S_SPIN);
  assign bus.paused    = paused;
  assign bus.phase     = phase_of(state);
  assign bus.remaining = remaining;
  assign bus.tens      = 4'(remaining / TIME_W'(10));
  assign bus.ones      = 4'(remaining % TIME_W'(10));
  assign bus.done      = done;
  assign bus.buzzer    = (state == S_DONE);
endmodule
